// File: rtl/rs_latch_driver_pkg.sv
// Shared definitions for the RS latch driver: FSM state encoding and counter widths.
package rs_latch_driver_pkg;

  localparam int DB_CNT_W    = 8;
  localparam int PULSE_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SET_P = 2'b01,
    RST_P = 2'b10,
    GAP   = 2'b11
  } state_t;

endpackage

// File: rtl/rs_latch_driver_if.sv
// Button inputs and latch-side outputs of the RS latch driver.
interface rs_latch_driver_if;
  logic set_btn;
  logic rst_btn;
  logic SDN;
  logic RDN;
  logic busy;
  logic conflict;
  logic dropped;

  modport master (
    output set_btn, rst_btn,
    input  SDN, RDN, busy, conflict, dropped
  );

  modport slave (
    input  set_btn, rst_btn,
    output SDN, RDN, busy, conflict, dropped
  );
endinterface

// File: rtl/rs_debounce.sv
// Two-flop synchroniser, optional debounce filter and rising-edge detect for one button.
// The filter exists only when RS_LATCH_DRIVER_DEBOUNCE_EN is defined.
module rs_debounce
  import rs_latch_driver_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_db
    $error("rs_debounce: DEBOUNCE_CYCLES out of range 1..255");
  end

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;
  logic level;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      prev_reg  <= level;
    end
  end

`ifdef RS_LATCH_DRIVER_DEBOUNCE_EN
  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_CNT_W-1:0] cnt_reg;
  logic                level_reg;

  // Counter tracks consecutive cycles the synchronised value disagrees with the level.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
    end else if (sync2_reg != level_reg) begin
      if (cnt_reg == CNT_LAST) begin
        level_reg <= sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end else begin
      cnt_reg <= '0;
    end
  end

  assign level = level_reg;
`else
  assign level = sync2_reg;
`endif

  assign rise = level & ~prev_reg;

endmodule

// File: rtl/rs_latch_driver.sv
// Drives the active-low SDN/RDN inputs of an RS latch from two debounced push buttons.
// Define RS_LATCH_DRIVER_DEBOUNCE_EN to include the debounce filter.
module rs_latch_driver
  import rs_latch_driver_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_WIDTH     = 2
) (
  input  logic               clk,
  input  logic               reset,
  rs_latch_driver_if.slave   bus
);

  if (PULSE_WIDTH < 1 || PULSE_WIDTH > 15) begin : g_bad_pw
    $error("rs_latch_driver: PULSE_WIDTH out of range 1..15");
  end

  localparam logic [PULSE_CNT_W-1:0] PULSE_LOAD = PULSE_CNT_W'(PULSE_WIDTH - 1);

  // Bit 0 is the set button, bit 1 the reset button.
  logic [1:0] btn_raw;
  logic [1:0] btn_rise;

  assign btn_raw = {bus.rst_btn, bus.set_btn};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    rs_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_raw[gi]),
      .rise  (btn_rise[gi])
    );
  end

  state_t                 state_reg;
  logic [PULSE_CNT_W-1:0] pcnt_reg;
  logic                   sdn_reg;
  logic                   rdn_reg;
  logic                   busy_reg;
  logic                   conflict_reg;
  logic                   dropped_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      pcnt_reg     <= '0;
      sdn_reg      <= 1'b1;
      rdn_reg      <= 1'b1;
      busy_reg     <= 1'b0;
      conflict_reg <= 1'b0;
      dropped_reg  <= 1'b0;
    end else begin
      conflict_reg <= 1'b0;
      dropped_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Coinciding edges are refused outright so the latch never sees both inputs low.
          if (btn_rise[0] && btn_rise[1]) begin
            conflict_reg <= 1'b1;
          end else if (btn_rise[0]) begin
            state_reg <= SET_P;
            sdn_reg   <= 1'b0;
            busy_reg  <= 1'b1;
            pcnt_reg  <= PULSE_LOAD;
          end else if (btn_rise[1]) begin
            state_reg <= RST_P;
            rdn_reg   <= 1'b0;
            busy_reg  <= 1'b1;
            pcnt_reg  <= PULSE_LOAD;
          end
        end
        SET_P, RST_P: begin
          dropped_reg <= |btn_rise;
          if (pcnt_reg == '0) begin
            state_reg <= GAP;
            sdn_reg   <= 1'b1;
            rdn_reg   <= 1'b1;
          end else begin
            pcnt_reg <= pcnt_reg - 1'b1;
          end
        end
        GAP: begin
          dropped_reg <= |btn_rise;
          state_reg   <= IDLE;
          busy_reg    <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          sdn_reg   <= 1'b1;
          rdn_reg   <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SDN      = sdn_reg;
  assign bus.RDN      = rdn_reg;
  assign bus.busy     = busy_reg;
  assign bus.conflict = conflict_reg;
  assign bus.dropped  = dropped_reg;

endmodule
